// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types for the ROM download writer.
// Holds the FSM states, the FIFO entry layout and the gfx base default.
package rom_dl_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    localparam logic [24:0] GFX_BASE_DEFAULT = 25'hC000;

    // Offset of a download address into the gfx region (wraps mod 2^25)
    function automatic logic [24:0] gfx_offset(
        input logic [24:0] addr,
        input logic [24:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];

    // Storage array; no reset needed since reads are gated by the count
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rom_download_writer.sv
// rom_download_writer: turns the ioctl byte stream into toggle-handshake
// SDRAM writes; CPU bytes go to port1, gfx bytes are remapped onto port2.
module rom_download_writer
    import rom_dl_pkg::*;
#(
    parameter logic [24:0] GFX_BASE   = GFX_BASE_DEFAULT,
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port2_we,
    output logic        rom_loaded,
    output logic        busy,
    output logic        overflow
);

    state_e      state_q;
    state_e      state_d;

    logic        wr_last_q;
    logic        downl_q;
    logic        ack1_meta_q;
    logic        ack1_s_q;
    logic        ack2_meta_q;
    logic        ack2_s_q;

    logic        req1_q;
    logic [22:0] a1_q;
    logic [1:0]  ds1_q;
    logic [15:0] d1_q;
    logic        req2_q;
    logic [22:0] a2_q;
    logic [1:0]  ds2_q;
    logic [15:0] d2_q;
    logic        pend_gfx_q;

    logic        loaded_q;
    logic        loaded_d;
    logic        seen_q;
    logic        overflow_q;

    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    entry_t      wr_entry;
    entry_t      head;
    logic        head_gfx;
    logic [24:0] g;
    logic        ack_match;
    logic        downl_rise;
    logic        unused_g;

    // Byte strobe is a level; one push per rising edge of ioctl_wr
    assign push = ioctl_downl & ioctl_wr & ~wr_last_q
                & (ioctl_index == ROM_INDEX);

    assign wr_entry = '{addr: ioctl_addr, data: ioctl_dout};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_sys),
        .rst_i   (reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_gfx = (head.addr >= GFX_BASE);
    assign g        = gfx_offset(head.addr, GFX_BASE);
    assign unused_g = g[24];

    assign ack_match = pend_gfx_q ? (ack2_s_q == req2_q)
                                  : (ack1_s_q == req1_q);

    assign downl_rise = ioctl_downl & ~downl_q;

    // Strobe edge history, download level history and ack synchronisers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_last_q   <= 1'b0;
            downl_q     <= 1'b0;
            ack1_meta_q <= 1'b0;
            ack1_s_q    <= 1'b0;
            ack2_meta_q <= 1'b0;
            ack2_s_q    <= 1'b0;
        end else begin
            wr_last_q   <= ioctl_wr;
            downl_q     <= ioctl_downl;
            ack1_meta_q <= port1_ack;
            ack1_s_q    <= ack1_meta_q;
            ack2_meta_q <= port2_ack;
            ack2_s_q    <= ack2_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave IDLE on a pop, leave WAIT once acked
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!fifo_empty) state_d = WAIT;
            WAIT: if (ack_match)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop the head only while idle
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            IDLE:    pop = ~fifo_empty;
            WAIT:    pop = 1'b0;
            default: pop = 1'b0;
        endcase
    end

    // Launch a write: latch the mapped fields and flip one port's req
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req1_q     <= 1'b0;
            a1_q       <= '0;
            ds1_q      <= '0;
            d1_q       <= '0;
            req2_q     <= 1'b0;
            a2_q       <= '0;
            ds2_q      <= '0;
            d2_q       <= '0;
            pend_gfx_q <= 1'b0;
        end else if (pop) begin
            if (head_gfx) begin
                req2_q     <= ~req2_q;
                a2_q       <= {g[23:15], g[13:0]};
                ds2_q      <= {~g[14], g[14]};
                d2_q       <= {head.data, head.data};
                pend_gfx_q <= 1'b1;
            end else begin
                req1_q     <= ~req1_q;
                a1_q       <= head.addr[23:1];
                ds1_q      <= {head.addr[0], ~head.addr[0]};
                d1_q       <= {head.data, head.data};
                pend_gfx_q <= 1'b0;
            end
        end
    end

    // Completion flag: cleared when a download starts, set once drained
    always_comb begin
        loaded_d = loaded_q;
        if (downl_rise) begin
            loaded_d = 1'b0;
        end else if (!ioctl_downl && seen_q && fifo_empty
                     && state_q == IDLE) begin
            loaded_d = 1'b1;
        end
    end

    // Completion flag, download-seen flag and sticky drop flag
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            loaded_q   <= 1'b0;
            seen_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            loaded_q <= loaded_d;
            if (downl_rise) begin
                seen_q <= 1'b1;
            end
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign port1_req  = req1_q;
    assign port1_a    = a1_q;
    assign port1_ds   = ds1_q;
    assign port1_d    = d1_q;
    assign port1_we   = downl_q;
    assign port2_req  = req2_q;
    assign port2_a    = a2_q;
    assign port2_ds   = ds2_q;
    assign port2_d    = d2_q;
    assign port2_we   = downl_q;
    assign rom_loaded = loaded_q;
    assign busy       = ~fifo_empty | (state_q == WAIT);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_download_writer.sv
// tb_rom_download_writer: randomized scoreboard bench for the ROM writer.
// A responder plays the sdram side and compares every request it sees.
module tb_rom_download_writer;

    localparam logic [24:0] GFX = 25'hC000;

    typedef struct {
        bit          gfx;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_downl = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        port1_req, port2_req;
    logic        ack1 = 1'b0, ack2 = 1'b0;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port1_we, port2_we;
    logic        rom_loaded, busy, overflow;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_delay = 3;
    int   ack_cyc = 0;
    int   req_cyc = 0;
    int   strobe_cyc = 0;
    int   nwrites = 0;
    bit   mon_busy = 1'b0;

    rom_download_writer dut (
        .clk_sys     (clk),
        .reset       (reset),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .port1_req   (port1_req),
        .port1_ack   (ack1),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_d     (port1_d),
        .port1_we    (port1_we),
        .port2_req   (port2_req),
        .port2_ack   (ack2),
        .port2_a     (port2_a),
        .port2_ds    (port2_ds),
        .port2_d     (port2_d),
        .port2_we    (port2_we),
        .rom_loaded  (rom_loaded),
        .busy        (busy),
        .overflow    (overflow)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp_v, cyc);
        end
    endtask

    // Reference: which port a byte lands on and where, from plain arithmetic
    function automatic exp_t model(input logic [24:0] addr,
                                   input logic [7:0] data);
        exp_t   e;
        longint ad;
        longint g;
        ad  = longint'(addr);
        e.d = {data, data};
        if (ad < longint'(GFX)) begin
            e.gfx = 1'b0;
            e.a   = 23'(ad / 2);
            e.ds  = (ad % 2 == 1) ? 2'b10 : 2'b01;
        end else begin
            g     = (ad + 33554432 - longint'(GFX)) % 33554432;
            e.gfx = 1'b1;
            e.a   = 23'(((g / 32768) % 512) * 16384 + g % 16384);
            e.ds  = ((g / 16384) % 2 == 1) ? 2'b01 : 2'b10;
        end
        return e;
    endfunction

    // One byte strobe: wr high for one cycle, low for one cycle
    task automatic strobe(input logic [24:0] addr, input logic [7:0] data,
                          input logic [7:0] idx, input bit keep);
        @(negedge clk);
        ioctl_addr  = addr;
        ioctl_dout  = data;
        ioctl_index = idx;
        ioctl_wr    = 1'b1;
        strobe_cyc  = cyc;
        if (keep && idx == 8'd0 && ioctl_downl) q.push_back(model(addr, data));
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", busy, 0);
        chk("idle_drained", q.size(), 0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sdram responder and scoreboard monitor
    initial begin
        bit          seen1 = 1'b0, seen2 = 1'b0, t1, t2, cur_gfx = 1'b0;
        int          cnt = 0;
        logic [40:0] hold = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                ack1     = 1'b0;
                ack2     = 1'b0;
                seen1    = 1'b0;
                seen2    = 1'b0;
                mon_busy = 1'b0;
            end else begin
                if (mon_busy) begin
                    if (cnt > 0) cnt--;
                    else begin
                        chk("hold_fields",
                            cur_gfx ? {port2_a, port2_ds, port2_d}
                                    : {port1_a, port1_ds, port1_d}, hold);
                        if (cur_gfx) ack2 = ~ack2;
                        else         ack1 = ~ack1;
                        ack_cyc  = cyc;
                        mon_busy = 1'b0;
                        nwrites++;
                    end
                end
                if (port1_req !== seen1 || port2_req !== seen2) begin
                    t1      = (port1_req !== seen1);
                    t2      = (port2_req !== seen2);
                    seen1   = port1_req;
                    seen2   = port2_req;
                    req_cyc = cyc;
                    chk("single_port_toggle", t1 & t2, 0);
                    chk("no_overlap", mon_busy, 0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: p1=%0b p2=%0b, none expected",
                                 t1, t2);
                    end else begin
                        e = q.pop_front();
                        chk("port_select", t2, e.gfx);
                        chk("addr", t2 ? port2_a : port1_a, e.a);
                        chk("ds", t2 ? port2_ds : port1_ds, e.ds);
                        chk("data", t2 ? port2_d : port1_d, e.d);
                    end
                    cur_gfx  = t2;
                    hold     = t2 ? {port2_a, port2_ds, port2_d}
                                  : {port1_a, port1_ds, port1_d};
                    mon_busy = 1'b1;
                    cnt      = ack_delay;
                end
            end
        end
    end

    initial begin
        int   base_w;
        int   n;
        logic [24:0] ra;
        logic [7:0]  ri;

        // Reset state
        cycles(3);
        chk("rst_reqs", {port1_req, port2_req}, 0);
        chk("rst_fields", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, 0);
        chk("rst_flags", {port1_we, port2_we, rom_loaded, busy, overflow}, 0);
        reset = 1'b0;
        cycles(2);

        // Single CPU byte, ack 5 cycles after req
        ioctl_downl = 1'b1;
        ack_delay   = 5;
        cycles(1);
        chk("we_high", {port1_we, port2_we}, 2'b11);
        strobe(25'h0003, 8'hA5, 8'd0, 1'b1);
        wait_idle(100);
        chk("req_latency", req_cyc - strobe_cyc, 2);
        chk("p1_req_once", port1_req, 1);
        chk("p2_untouched", port2_req, 0);
        ioctl_downl = 1'b0;
        cycles(2);
        chk("loaded_after_dl1", rom_loaded, 1);

        // Gfx remap cases
        ioctl_downl = 1'b1;
        cycles(1);
        chk("loaded_cleared", rom_loaded, 0);
        ack_delay = 2;
        strobe(25'h10000, 8'h12, 8'd0, 1'b1);
        strobe(25'h0C001, 8'h34, 8'd0, 1'b1);
        strobe(25'h0BFFF, 8'h56, 8'd0, 1'b1);
        wait_idle(200);

        // Foreign index: nothing is pushed
        base_w = nwrites;
        strobe(25'h0010, 8'h77, 8'd1, 1'b0);
        strobe(25'h0D000, 8'h88, 8'd1, 1'b0);
        strobe(25'h0011, 8'h99, 8'd1, 1'b0);
        cycles(10);
        chk("idx_busy", busy, 0);
        chk("idx_no_writes", nwrites - base_w, 0);

        // Randomized stream with flow control so nothing is dropped
        for (int i = 0; i < 60; i++) begin
            n = 0;
            while (q.size() >= 3 && n < 200) begin
                @(negedge clk);
                n++;
            end
            case ($urandom_range(0, 3))
                0: ra = 25'($urandom_range(0, 32'hBFFF));
                1: ra = 25'($urandom_range(32'hBFF0, 32'hC00F));
                2: ra = 25'($urandom_range(32'hC000, 32'h1FFFF));
                default: ra = 25'($urandom);
            endcase
            ri = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
            ack_delay = $urandom_range(0, 6);
            strobe(ra, 8'($urandom), ri, 1'b1);
            cycles($urandom_range(0, 3));
        end
        wait_idle(400);
        chk("no_overflow_yet", overflow, 0);
        ioctl_downl = 1'b0;
        cycles(2);
        chk("loaded_after_rand", rom_loaded, 1);

        // Burst of 6 with a slow ack: only 5 survive
        ioctl_downl = 1'b1;
        ack_delay   = 20;
        base_w      = nwrites;
        for (int i = 0; i < 6; i++)
            strobe(25'(16 + i), 8'(8'h40 + i), 8'd0, i < 5);
        chk("burst_overflow", overflow, 1);
        wait_idle(400);
        chk("burst_writes", nwrites - base_w, 5);

        // Download ends with bytes still pending
        ioctl_downl = 1'b0;
        cycles(2);
        ioctl_downl = 1'b1;
        ack_delay   = 8;
        base_w      = nwrites;
        for (int i = 0; i < 4; i++)
            strobe(25'(32'h100 + i), 8'($urandom), 8'd0, 1'b1);
        ioctl_downl = 1'b0;
        chk("pending_at_fall", busy, 1);
        cycles(2);
        chk("loaded_held_low", rom_loaded, 0);
        n = 0;
        while (!rom_loaded && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("loaded_rose", rom_loaded, 1);
        chk("loaded_latency", cyc - ack_cyc, 4);
        chk("pend_writes", nwrites - base_w, 4);

        // Reset while waiting for an ack
        ioctl_downl = 1'b1;
        ack_delay   = 30;
        strobe(25'h0200, 8'hC3, 8'd0, 1'b1);
        cycles(5);
        chk("in_wait", busy, 1);
        q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_reqs", {port1_req, port2_req}, 0);
        chk("mid_rst_fields", {port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d}, 0);
        chk("mid_rst_flags", {port1_we, port2_we, rom_loaded, busy, overflow}, 0);
        cycles(2);
        reset     = 1'b0;
        ack_delay = 3;
        cycles(1);
        strobe(25'h14001, 8'h5A, 8'd0, 1'b1);
        wait_idle(100);
        chk("post_rst_p2", port2_req, 1);
        chk("post_rst_p1", port1_req, 0);
        ioctl_downl = 1'b0;
        cycles(2);
        chk("post_rst_loaded", rom_loaded, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
